// File: rtl/psat_accum_ctrl.sv
// Packed-byte saturating accumulator sequencer: reduces a stream of 16-bit words
// into two independent signed 8-bit lanes and keeps a sticky clamp flag per lane.
module psat_accum_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [1:0]       out_sat,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [1:0]       sat_q, sat_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [15:0]      lane_sum;
    logic [1:0]       lane_clamp;
    logic             xfer;

    // Each lane saturates on its own; no carry crosses the byte boundary.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] a, b, s;
            logic       clamp_pos, clamp_neg;
            assign a         = acc_q[gi*8 +: 8];
            assign b         = in_data[gi*8 +: 8];
            assign s         = a + b;
            assign clamp_pos = ~a[7] & ~b[7] &  s[7];
            assign clamp_neg =  a[7] &  b[7] & ~s[7];
            assign lane_sum[gi*8 +: 8] = clamp_pos ? 8'h7F : (clamp_neg ? 8'h80 : s);
            assign lane_clamp[gi]      = clamp_pos | clamp_neg;
        end
    endgenerate

    assign xfer = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = 16'h0000;
                    sat_d = 2'b00;
                    if (count != '0) begin
                        rem_d   = count;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d = lane_sum;
                    sat_d = sat_q | lane_clamp;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            sat_q   <= 2'b00;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_psat_accum_ctrl.sv
// Directed bench for psat_accum_ctrl: a table of back-to-back operations plus
// hand-written stall, zero-count and mid-operation reset sequences.
module tb_psat_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  count;
    logic        busy;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_sat;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psat_accum_ctrl #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [3:0]       cnt;
        logic [2:0][15:0] w;
        logic [15:0]      exp_d;
        logic [1:0]       exp_s;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an operation, stream words back-to-back, then check and drain the result.
    task automatic run_op(input logic [3:0] cnt, input logic [2:0][15:0] w,
                          input logic [15:0] exp_d, input logic [1:0] exp_s);
        start = 1'b1;
        count = cnt;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < int'(cnt); i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            chk("in_ready_accum", 32'(in_ready), 32'd1);
            chk("no_early_valid", 32'(out_valid), 32'd0);
            tick();
            in_valid = 1'b0;
        end
        chk("out_valid_rise", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("out_data", 32'(out_data), 32'(exp_d));
        chk("out_sat", 32'(out_sat), 32'(exp_s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_fall", 32'(out_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("out_data_hold_idle", 32'(out_data), 32'(exp_d));
        $display("op count=%0d data=%04h sat=%02b (exp %04h %02b)", cnt, out_data, out_sat, exp_d, exp_s);
    endtask

    initial begin
        vecs[0] = '{cnt: 4'd2, w: {16'h0000, 16'h0304, 16'h0102}, exp_d: 16'h0406, exp_s: 2'b00};
        vecs[1] = '{cnt: 4'd2, w: {16'h0000, 16'h0110, 16'h7F10}, exp_d: 16'h7F20, exp_s: 2'b10};
        vecs[2] = '{cnt: 4'd3, w: {16'h0101, 16'hFFFF, 16'h8080}, exp_d: 16'h8181, exp_s: 2'b11};
        vecs[3] = '{cnt: 4'd2, w: {16'h0000, 16'h40C0, 16'h40C0}, exp_d: 16'h7F80, exp_s: 2'b10};
        vecs[4] = '{cnt: 4'd2, w: {16'h0000, 16'h8001, 16'h7F80}, exp_d: 16'hFF81, exp_s: 2'b00};
        vecs[5] = '{cnt: 4'd1, w: {16'h0000, 16'h0000, 16'hC040}, exp_d: 16'hC040, exp_s: 2'b00};

        rst_n = 1'b0; start = 1'b0; count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].cnt, vecs[v].w, vecs[v].exp_d, vecs[v].exp_s);
        end

        // Gapped input, stalled consumer, start pulses while busy.
        start = 1'b1; count = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            for (int g = 0; g < 2; g++) begin
                chk("gap_in_ready", 32'(in_ready), 32'd1);
                tick();
            end
            chk("gap_no_valid", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = 16'(i * 16'h0101);
            tick();
            in_valid = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'h0606);
            chk("stall_sat", 32'(out_sat), 32'd0);
            start = (s == 1);
            count = 4'd5;
            tick();
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("start_ignored_busy", 32'(busy), 32'd0);
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        $display("stall op data=%04h sat=%02b", out_data, out_sat);

        // Zero-length operation goes straight to DONE and clears prior result.
        start = 1'b1; count = 4'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111;
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_in_ready", 32'(in_ready), 32'd0);
        chk("zero_data", 32'(out_data), 32'd0);
        chk("zero_sat", 32'(out_sat), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("zero_data_hold", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("zero_idle", 32'(busy), 32'd0);
        $display("zero-count op data=%04h sat=%02b", out_data, out_sat);

        // Reset in the middle of an accumulation.
        start = 1'b1; count = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h7F7F;
        tick();
        in_valid = 1'b0;
        chk("mid_acc_data", 32'(out_data), 32'h7F7F);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_sat", 32'(out_sat), 32'd0);
        $display("mid-op reset busy=%0d data=%04h", busy, out_data);
        run_op(4'd1, {16'h0000, 16'h0000, 16'h0505}, 16'h0505, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
